// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single physical memory port between the LC-3b
// instruction cache and data cache, round-robin on simultaneous misses.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  state_t            state;
  grant_t            last_grant;
  logic              op_read;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the client that was not served last wins; last_grant resets to I
  // so the very first tie goes to the data cache.
  assign pick_d = d_req && (!i_req || (last_grant == GRANT_I));

  // The strobes are cleared on the completion edge, so the IDLE cycle that
  // follows every transaction never drives memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      op_read    <= 1'b0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            if (pick_d) begin
              state      <= SERVE_D;
              last_grant <= GRANT_D;
              op_read    <= d_read;
              op_write   <= d_write;
              addr_q     <= d_address;
              wdata_q    <= d_wdata;
            end else begin
              state      <= SERVE_I;
              last_grant <= GRANT_I;
              op_read    <= 1'b1;
              op_write   <= 1'b0;
              addr_q     <= i_address;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state    <= IDLE;
            op_read  <= 1'b0;
            op_write <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          op_read  <= 1'b0;
          op_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = op_read;
  assign pmem_write   = op_write;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion is forwarded only to the owner and never while reset abandons
  // the transaction.
  assign i_resp  = pmem_resp && !reset && (state == SERVE_I);
  assign d_resp  = pmem_resp && !reset && (state == SERVE_D);
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model of who owns the memory port.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Model: which client currently owns memory and the transaction it posted.
  typedef enum {OWN_NONE, OWN_I, OWN_D} owner_t;
  owner_t            m_owner = OWN_NONE;
  owner_t            m_last  = OWN_I;
  logic              m_read  = 1'b0;
  logic              m_write = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [LINE_W-1:0] m_wdata = '0;
  bit                model_valid = 1'b0;
  logic              exp_i_resp;
  logic              exp_d_resp;

  int mem_cnt   = 0;
  bit i_served  = 1'b0;
  bit d_served  = 1'b0;

  localparam logic [LINE_W-1:0] WB_LINE = 128'h0123456789abcdef0123456789abcdef;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    owner_t pick;
    if (reset) begin
      m_owner = OWN_NONE;
      m_last  = OWN_I;
      m_read  = 1'b0;
      m_write = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
    end else if (m_owner == OWN_NONE) begin
      pick = OWN_NONE;
      if (i_read && (d_read || d_write)) pick = (m_last == OWN_I) ? OWN_D : OWN_I;
      else if (i_read) pick = OWN_I;
      else if (d_read || d_write) pick = OWN_D;
      if (pick == OWN_I) begin
        m_owner = OWN_I;
        m_last  = OWN_I;
        m_read  = 1'b1;
        m_write = 1'b0;
        m_addr  = i_address;
      end else if (pick == OWN_D) begin
        m_owner = OWN_D;
        m_last  = OWN_D;
        m_read  = d_read;
        m_write = d_write;
        m_addr  = d_address;
        m_wdata = d_wdata;
      end
    end else if (pmem_resp) begin
      m_owner = OWN_NONE;
      m_read  = 1'b0;
      m_write = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      exp_i_resp = (m_owner == OWN_I) && pmem_resp && !reset;
      exp_d_resp = (m_owner == OWN_D) && pmem_resp && !reset;
      checkOutput("pmem_read", 128'(pmem_read), 128'(m_read));
      checkOutput("pmem_write", 128'(pmem_write), 128'(m_write));
      checkOutput("pmem_address", 128'(pmem_address), 128'(m_addr));
      checkOutput("pmem_wdata", pmem_wdata, m_wdata);
      checkOutput("i_resp", 128'(i_resp), 128'(exp_i_resp));
      checkOutput("d_resp", 128'(d_resp), 128'(exp_d_resp));
      checkOutput("i_rdata", i_rdata, pmem_rdata);
      checkOutput("d_rdata", d_rdata, pmem_rdata);
    end
  end

  task automatic reset_dut();
    reset = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    tick();
    model_valid = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic serve_grant(input int lat, input logic [LINE_W-1:0] rdata);
    pmem_rdata = rdata;
    for (int k = 1; k <= lat; k++) begin
      pmem_resp = (k == lat);
      if (k < lat) tick();
    end
  endtask

  // Well-behaved clients that hold requests until served, with occasional
  // illegal drops, mid-transaction input churn, spurious memory responses
  // in IDLE and random reset pulses.
  task automatic applyStimulus();
    if (m_owner != OWN_NONE) begin
      if (mem_cnt == 0) mem_cnt = $urandom_range(1, 4);
      pmem_resp = (mem_cnt == 1);
      mem_cnt--;
    end else begin
      mem_cnt   = 0;
      pmem_resp = ($urandom_range(0, 9) == 0);
    end
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    reset = ($urandom_range(0, 149) == 0);

    if (!i_read || i_served) i_read = ($urandom_range(0, 2) == 0);
    else if ($urandom_range(0, 63) == 0) i_read = 1'b0;
    i_address = 16'($urandom);

    if (!(d_read || d_write) || d_served) begin
      case ($urandom_range(0, 3))
        0: begin d_read = 1'b1; d_write = 1'b0; end
        1: begin d_read = 1'b0; d_write = 1'b1; end
        default: begin d_read = 1'b0; d_write = 1'b0; end
      endcase
    end else if ($urandom_range(0, 63) == 0) begin
      d_read = 1'b0; d_write = 1'b0;
    end
    d_address = 16'($urandom);
    d_wdata   = {$urandom, $urandom, $urandom, $urandom};

    i_served = pmem_resp && !reset && (m_owner == OWN_I);
    d_served = pmem_resp && !reset && (m_owner == OWN_D);
  endtask

  initial begin
    reset = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    reset_dut();
    #1;
    checkOutput("reset_pmem_read", 128'(pmem_read), 128'd0);
    checkOutput("reset_pmem_address", 128'(pmem_address), 128'd0);

    $display("[TB] tie arbitration after reset");
    i_address = 16'h1000; d_address = 16'h2000; d_wdata = WB_LINE;
    for (int r = 0; r < 4; r++) begin
      i_read = 1'b1; d_read = 1'b1;
      tick();
      #1;
      checkOutput("tie_grant_addr", 128'(pmem_address), (r % 2 == 0) ? 128'h2000 : 128'h1000);
      serve_grant(2, {4{32'h5a5a_0000 + 32'(r)}});
      #1;
      checkOutput("tie_d_resp", 128'(d_resp), (r % 2 == 0) ? 128'd1 : 128'd0);
      checkOutput("tie_i_resp", 128'(i_resp), (r % 2 == 0) ? 128'd0 : 128'd1);
      if (r % 2 == 0) d_read = 1'b0;
      else i_read = 1'b0;
      tick();
      pmem_resp = 1'b0;
      #1;
      checkOutput("tie_idle_gap", 128'(pmem_read), 128'd0);
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();

    $display("[TB] lone icache read");
    i_read = 1'b1; i_address = 16'h1230;
    tick();
    for (int k = 1; k <= 3; k++) begin
      pmem_rdata = {16{8'hAA}};
      pmem_resp  = (k == 3);
      #1;
      checkOutput("ird_pmem_read", 128'(pmem_read), 128'd1);
      checkOutput("ird_pmem_addr", 128'(pmem_address), 128'h1230);
      checkOutput("ird_i_resp", 128'(i_resp), (k == 3) ? 128'd1 : 128'd0);
      checkOutput("ird_d_resp", 128'(d_resp), 128'd0);
      if (k < 3) tick();
    end
    checkOutput("ird_i_rdata", i_rdata, {16{8'hAA}});
    i_read = 1'b0;
    tick();
    pmem_resp = 1'b0;
    #1;
    checkOutput("ird_after_resp", 128'(i_resp), 128'd0);
    checkOutput("ird_after_read", 128'(pmem_read), 128'd0);

    $display("[TB] dcache write-back with mid-grant input change");
    d_write = 1'b1; d_address = 16'h4560; d_wdata = WB_LINE;
    tick();
    #1;
    checkOutput("wb_pmem_write", 128'(pmem_write), 128'd1);
    checkOutput("wb_pmem_read", 128'(pmem_read), 128'd0);
    checkOutput("wb_pmem_wdata", pmem_wdata, WB_LINE);
    d_address = 16'hFFF0; d_wdata = ~WB_LINE;
    for (int k = 1; k <= 3; k++) begin
      pmem_resp = (k == 3);
      #1;
      checkOutput("wb_hold_addr", 128'(pmem_address), 128'h4560);
      checkOutput("wb_hold_wdata", pmem_wdata, WB_LINE);
      checkOutput("wb_d_resp", 128'(d_resp), (k == 3) ? 128'd1 : 128'd0);
      checkOutput("wb_i_resp", 128'(i_resp), 128'd0);
      if (k < 3) tick();
    end
    d_write = 1'b0;
    tick();
    pmem_resp = 1'b0;
    #1;
    checkOutput("wb_single_pulse", 128'(d_resp), 128'd0);
    checkOutput("wb_strobe_off", 128'(pmem_write), 128'd0);

    $display("[TB] back-to-back dcache reads");
    d_read = 1'b1; d_address = 16'h2000;
    tick();
    #1;
    checkOutput("ldi1_addr", 128'(pmem_address), 128'h2000);
    serve_grant(2, {4{32'h1111_2222}});
    #1;
    checkOutput("ldi1_resp", 128'(d_resp), 128'd1);
    tick();
    pmem_resp = 1'b0; d_address = 16'h3000;
    #1;
    checkOutput("ldi_gap_read", 128'(pmem_read), 128'd0);
    checkOutput("ldi_gap_resp", 128'(d_resp), 128'd0);
    tick();
    #1;
    checkOutput("ldi2_addr", 128'(pmem_address), 128'h3000);
    checkOutput("ldi2_read", 128'(pmem_read), 128'd1);
    serve_grant(3, {4{32'h3333_4444}});
    #1;
    checkOutput("ldi2_resp", 128'(d_resp), 128'd1);
    d_read = 1'b0;
    tick();
    pmem_resp = 1'b0;

    $display("[TB] reset during icache transaction");
    i_read = 1'b1; i_address = 16'h5550;
    tick();
    #1;
    checkOutput("rst_pre_read", 128'(pmem_read), 128'd1);
    reset = 1'b1;
    tick();
    #1;
    checkOutput("rst_strobe_clear", 128'(pmem_read), 128'd0);
    checkOutput("rst_addr_clear", 128'(pmem_address), 128'd0);
    reset = 1'b0; i_read = 1'b0; pmem_resp = 1'b1;
    #1;
    checkOutput("rst_no_resp", 128'(i_resp), 128'd0);
    tick();
    pmem_resp = 1'b0;

    $display("[TB] randomized traffic");
    mem_cnt = 0; i_served = 1'b0; d_served = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
